// File: rtl/smg_pkg.sv
// Shared definitions for the seven-segment scanner: hex font, dp bit position
// and the output polarity helper.
package smg_pkg;

  localparam int unsigned DP_BIT = 7;

  // Active-high segment patterns, bit order g..a; 6 and 9 drawn with tails.
  localparam logic [6:0] HEX_FONT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic logic pol_apply(input logic v, input logic act);
    return ~(v ^ act);
  endfunction

endpackage

// File: rtl/smg_scan_mux_if.sv
// Host-side bundle of the scanner: display data/control in, pin drive out.
// blink_i exists only when SMG_BLINK_EN is defined.
interface smg_scan_mux_if #(
  parameter int unsigned N_DIG    = 6,
  parameter int unsigned BRIGHT_W = 4
);
  logic [4*N_DIG-1:0]  digits_i;
  logic [N_DIG-1:0]    dp_i;
  logic [N_DIG-1:0]    blank_i;
  logic                lzb_en_i;
  logic [BRIGHT_W-1:0] bright_i;
  logic                load_i;
`ifdef SMG_BLINK_EN
  logic [N_DIG-1:0]    blink_i;
`endif
  logic [N_DIG-1:0]    sel_o;
  logic [7:0]          dig_o;
  logic                frame_o;

  modport master (
`ifdef SMG_BLINK_EN
    output blink_i,
`endif
    output digits_i, dp_i, blank_i, lzb_en_i, bright_i, load_i,
    input  sel_o, dig_o, frame_o
  );

  modport slave (
`ifdef SMG_BLINK_EN
    input  blink_i,
`endif
    input  digits_i, dp_i, blank_i, lzb_en_i, bright_i, load_i,
    output sel_o, dig_o, frame_o
  );
endinterface

// File: rtl/smg_hex_decode.sv
// Combinational nibble to active-high seven-segment pattern (g..a).
module smg_hex_decode
  import smg_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);
  assign seg_o = HEX_FONT[nib_i];
endmodule

// File: rtl/smg_scan_mux.sv
// Multiplexed seven-segment scanner: PWM brightness with dead time, leading-zero
// blanking, frame-aligned shadow loading. Optional blink: define SMG_BLINK_EN.
module smg_scan_mux
  import smg_pkg::*;
#(
`ifdef SMG_BLINK_EN
  parameter int unsigned BLINK_FRAMES = 64,
`endif
  parameter int unsigned N_DIG    = 6,
  parameter int unsigned SCAN_DIV = 50000,
  parameter int unsigned DEAD     = 64,
  parameter int unsigned BRIGHT_W = 4,
  parameter bit          SEL_ACT  = 1'b0,
  parameter bit          SEG_ACT  = 1'b0
) (
  input logic           clk,
  input logic           rst,
  smg_scan_mux_if.slave bus
);

  localparam int unsigned CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IW = (N_DIG > 1) ? $clog2(N_DIG) : 1;
  localparam logic [N_DIG-1:0] SEL_OFF = {N_DIG{~SEL_ACT}};
  localparam logic [7:0]       DIG_OFF = {8{~SEG_ACT}};

  logic [CW-1:0]      cnt_q, cnt_d, on_len_q, on_len_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [4*N_DIG-1:0] pdig_q, pdig_d, adig_q, adig_d;
  logic [N_DIG-1:0]   pdp_q, pdp_d, adp_q, adp_d;
  logic [N_DIG-1:0]   pblank_q, pblank_d, ablank_q, ablank_d;
  logic [N_DIG-1:0]   sel_q, sel_d;
  logic [7:0]         dig_q, dig_d;
  logic               frame_q, frame_d;
  logic               slot_end, frame_end, lit, dark, lzb_hide;
  logic [3:0]         nib;
  logic [6:0]         seg;
  logic [7:0]         raw;
  int unsigned        on_len_now, on_len_eff;

  assign nib = adig_q[4*idx_q +: 4];

  smg_hex_decode u_dec (
    .nib_i (nib),
    .seg_o (seg)
  );

  // Slot timing; on_len is taken straight from bright_i on the cnt==0 cycle so
  // that a zero dead time still lights the first clock of the slot.
  always_comb begin
    slot_end   = (cnt_q == CW'(SCAN_DIV - 1));
    frame_end  = slot_end && (idx_q == IW'(N_DIG - 1));
    cnt_d      = slot_end ? '0 : cnt_q + 1'b1;
    idx_d      = idx_q;
    if (slot_end) idx_d = frame_end ? '0 : idx_q + 1'b1;
    on_len_now = ((SCAN_DIV - DEAD) * 32'(bus.bright_i)) >> BRIGHT_W;
    on_len_eff = (cnt_q == '0) ? on_len_now : 32'(on_len_q);
    on_len_d   = CW'(on_len_eff);
    lit        = (32'(cnt_q) >= DEAD) && (32'(cnt_q) < DEAD + on_len_eff);
  end

  always_comb begin
    pdig_d   = pdig_q;
    pdp_d    = pdp_q;
    pblank_d = pblank_q;
    if (bus.load_i) begin
      pdig_d   = bus.digits_i;
      pdp_d    = bus.dp_i;
      pblank_d = bus.blank_i;
    end
    adig_d   = frame_end ? pdig_q   : adig_q;
    adp_d    = frame_end ? pdp_q    : adp_q;
    ablank_d = frame_end ? pblank_q : ablank_q;
  end

`ifdef SMG_BLINK_EN
  localparam int unsigned BCW = $clog2(BLINK_FRAMES + 1);

  logic [N_DIG-1:0] pblink_q, pblink_d, ablink_q, ablink_d;
  logic [BCW-1:0]   bcnt_q, bcnt_d;
  logic             phase_q, phase_d;

  always_comb begin
    pblink_d = bus.load_i ? bus.blink_i : pblink_q;
    ablink_d = frame_end ? pblink_q : ablink_q;
    bcnt_d   = bcnt_q;
    phase_d  = phase_q;
    if (frame_end) begin
      if (bcnt_q == BCW'(BLINK_FRAMES - 1)) begin
        bcnt_d  = '0;
        phase_d = ~phase_q;
      end else begin
        bcnt_d = bcnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pblink_q <= '0;
      ablink_q <= '0;
      bcnt_q   <= '0;
      phase_q  <= 1'b1;
    end else begin
      pblink_q <= pblink_d;
      ablink_q <= ablink_d;
      bcnt_q   <= bcnt_d;
      phase_q  <= phase_d;
    end
  end
`endif

  // Zero digits above the current one hide it; digit 0 is never hidden.
  always_comb begin
    lzb_hide = bus.lzb_en_i && (idx_q != '0);
    for (int unsigned k = 0; k < N_DIG; k++) begin
      if (k >= 32'(idx_q) && adig_q[4*k +: 4] != 4'h0) lzb_hide = 1'b0;
    end
    dark = ablank_q[idx_q];
`ifdef SMG_BLINK_EN
    dark = dark | (ablink_q[idx_q] & ~phase_q);
`endif
    raw = '0;
    if (lit && !dark) begin
      raw[6:0]    = lzb_hide ? 7'h00 : seg;
      raw[DP_BIT] = adp_q[idx_q];
    end
    for (int unsigned k = 0; k < N_DIG; k++) begin
      sel_d[k] = pol_apply(lit && (32'(idx_q) == k), SEL_ACT);
    end
    for (int unsigned b = 0; b < 8; b++) begin
      dig_d[b] = pol_apply(raw[b], SEG_ACT);
    end
    frame_d = (cnt_q == '0) && (idx_q == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      idx_q    <= '0;
      on_len_q <= '0;
      pdig_q   <= '0;
      adig_q   <= '0;
      pdp_q    <= '0;
      adp_q    <= '0;
      pblank_q <= '1;
      ablank_q <= '1;
      sel_q    <= SEL_OFF;
      dig_q    <= DIG_OFF;
      frame_q  <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      on_len_q <= on_len_d;
      pdig_q   <= pdig_d;
      adig_q   <= adig_d;
      pdp_q    <= pdp_d;
      adp_q    <= adp_d;
      pblank_q <= pblank_d;
      ablank_q <= ablank_d;
      sel_q    <= sel_d;
      dig_q    <= dig_d;
      frame_q  <= frame_d;
    end
  end

  assign bus.sel_o   = sel_q;
  assign bus.dig_o   = dig_q;
  assign bus.frame_o = frame_q;

endmodule

// File: tb/tb_smg_scan_mux.sv
// Bench for smg_scan_mux (4 digits, 16-clock slots, dead time 2) against a
// time-indexed behavioural model of the display.
module tb_smg_scan_mux;
  localparam int ND = 4, SD = 16, DD = 2, BW = 4;
  localparam int FRAME = SD * ND;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  smg_scan_mux_if #(.N_DIG(ND), .BRIGHT_W(BW)) bus ();

  smg_scan_mux #(
`ifdef SMG_BLINK_EN
    .BLINK_FRAMES(2),
`endif
    .N_DIG(ND), .SCAN_DIV(SD), .DEAD(DD), .BRIGHT_W(BW),
    .SEL_ACT(1'b0), .SEG_ACT(1'b0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [6:0] font [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  int total, bad;
  int t, onlen, last_cnt, last_idx;
  logic [15:0] pdig, adig;
  logic [3:0]  pdp, adp, pblank, ablank, pblink, ablink;
  logic [3:0]  exp_sel;
  logic [7:0]  exp_dig;
  logic        exp_frame;

  task automatic model_reset();
    t = 0; onlen = 0;
    pdig = '0; adig = '0; pdp = '0; adp = '0;
    pblank = '1; ablank = '1; pblink = '0; ablink = '0;
  endtask

  // Predict the outputs registered at the next edge, then advance one clock.
  task automatic tick();
    int cnt, idx;
    bit lit, off;
    logic [6:0] seg;
    cnt = t % SD;
    idx = (t / SD) % ND;
    if (cnt == 0) onlen = ((SD - DD) * int'(bus.bright_i)) >> BW;
    lit = (cnt >= DD) && (cnt < DD + onlen);
    off = ablank[idx];
`ifdef SMG_BLINK_EN
    if (ablink[idx] && ((t / FRAME) / 2) % 2 == 1) off = 1'b1;
`endif
    exp_frame = (cnt == 0) && (idx == 0);
    exp_sel = 4'hF;
    exp_dig = 8'hFF;
    if (lit) begin
      exp_sel[idx] = 1'b0;
      if (!off) begin
        seg = font[adig[4*idx +: 4]];
        if (bus.lzb_en_i && idx != 0 && (adig >> (4*idx)) == 16'h0) seg = '0;
        exp_dig = ~{adp[idx], seg};
      end
    end
    if ((t + 1) % FRAME == 0) begin
      adig = pdig; adp = pdp; ablank = pblank; ablink = pblink;
    end
    if (bus.load_i) begin
      pdig = bus.digits_i; pdp = bus.dp_i; pblank = bus.blank_i;
`ifdef SMG_BLINK_EN
      pblink = bus.blink_i;
`endif
    end
    last_cnt = cnt;
    last_idx = idx;
    @(posedge clk);
    t++;
    #1;
  endtask

  task automatic load(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] bl);
    bus.digits_i = d; bus.dp_i = dp; bus.blank_i = bl; bus.load_i = 1'b1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (bus.sel_o !== 4'hF) begin bad++; $display("FAIL reset_sel: got %b want 1111", bus.sel_o); end
    total++;
    if (bus.dig_o !== 8'hFF) begin bad++; $display("FAIL reset_dig: got %h want ff", bus.dig_o); end
    total++;
    if (bus.frame_o !== 1'b0) begin bad++; $display("FAIL reset_frame: got %b want 0", bus.frame_o); end
    rst = 1'b0;
    model_reset();
    repeat (FRAME) begin
      tick();
      total++;
      if (bus.sel_o !== exp_sel || bus.dig_o !== exp_dig || bus.frame_o !== exp_frame) begin
        bad++;
        $display("FAIL dark_after_reset t=%0d: got %b/%h/%b want %b/%h/%b", t, bus.sel_o, bus.dig_o, bus.frame_o, exp_sel, exp_dig, exp_frame);
      end
    end
  endtask

  task automatic test_basic();
    bus.bright_i = 4'd15; bus.lzb_en_i = 1'b0;
    load(16'h7125, 4'h0, 4'h0);
    tick();
    bus.load_i = 1'b0;
    while (t % FRAME != 0) tick();
    repeat (2 * FRAME) begin
      tick();
      total++;
      if (bus.sel_o !== exp_sel || bus.dig_o !== exp_dig || bus.frame_o !== exp_frame) begin
        bad++;
        $display("FAIL basic t=%0d: got %b/%h/%b want %b/%h/%b", t, bus.sel_o, bus.dig_o, bus.frame_o, exp_sel, exp_dig, exp_frame);
      end
      if (last_cnt == 5 && last_idx == 0) begin
        total++;
        if (bus.sel_o !== 4'b1110 || bus.dig_o !== 8'h92) begin
          bad++; $display("FAIL basic_digit0: got %b/%h want 1110/92", bus.sel_o, bus.dig_o);
        end
      end
      if (last_cnt == 5 && last_idx == 3) begin
        total++;
        if (bus.sel_o !== 4'b0111 || bus.dig_o !== 8'hF8) begin
          bad++; $display("FAIL basic_digit3: got %b/%h want 0111/f8", bus.sel_o, bus.dig_o);
        end
      end
    end
  endtask

  task automatic test_lzb();
    logic [7:0] want [4] = '{8'hC0, 8'h99, 8'hFF, 8'hFF};
    bus.lzb_en_i = 1'b1;
    load(16'h0040, 4'h0, 4'h0);
    tick();
    bus.load_i = 1'b0;
    while (t % FRAME != 0) tick();
    repeat (FRAME) begin
      tick();
      total++;
      if (bus.sel_o !== exp_sel || bus.dig_o !== exp_dig || bus.frame_o !== exp_frame) begin
        bad++;
        $display("FAIL lzb t=%0d: got %b/%h/%b want %b/%h/%b", t, bus.sel_o, bus.dig_o, bus.frame_o, exp_sel, exp_dig, exp_frame);
      end
      if (last_cnt == 7) begin
        total++;
        if (bus.dig_o !== want[last_idx]) begin
          bad++; $display("FAIL lzb_digit%0d: got %h want %h", last_idx, bus.dig_o, want[last_idx]);
        end
      end
    end
    bus.lzb_en_i = 1'b0;
  endtask

  task automatic test_bright();
    logic [3:0] want;
    bus.bright_i = 4'd0;
    while (t % SD != 0) tick();
    repeat (FRAME) begin
      tick();
      total++;
      if (bus.sel_o !== 4'hF) begin bad++; $display("FAIL bright0 t=%0d: got %b want 1111", t, bus.sel_o); end
    end
    bus.bright_i = 4'd8;
    while (t % SD != 0) tick();
    repeat (FRAME) begin
      tick();
      want = (last_cnt >= 2 && last_cnt <= 8) ? ~(4'b0001 << last_idx) : 4'hF;
      total++;
      if (bus.sel_o !== want || bus.dig_o !== exp_dig) begin
        bad++; $display("FAIL bright8 cnt=%0d: got %b/%h want %b/%h", last_cnt, bus.sel_o, bus.dig_o, want, exp_dig);
      end
    end
    bus.bright_i = 4'd15;
  endtask

  task automatic test_shadow();
    while (t % FRAME != FRAME / 2) tick();
    load(16'h89AB, 4'h0, 4'h0);
    tick();
    bus.load_i = 1'b0;
    while ((t + 1) % FRAME != 0) begin
      tick();
      total++;
      if (bus.sel_o !== exp_sel || bus.dig_o !== exp_dig || bus.frame_o !== exp_frame) begin
        bad++;
        $display("FAIL shadow_mid t=%0d: got %b/%h/%b want %b/%h/%b", t, bus.sel_o, bus.dig_o, bus.frame_o, exp_sel, exp_dig, exp_frame);
      end
    end
    load(16'h1234, 4'h0, 4'h0);
    tick();
    bus.load_i = 1'b0;
    for (int f = 0; f < 2; f++) begin
      repeat (FRAME) begin
        tick();
        total++;
        if (bus.sel_o !== exp_sel || bus.dig_o !== exp_dig || bus.frame_o !== exp_frame) begin
          bad++;
          $display("FAIL shadow_edge t=%0d: got %b/%h/%b want %b/%h/%b", t, bus.sel_o, bus.dig_o, bus.frame_o, exp_sel, exp_dig, exp_frame);
        end
        if (last_cnt == 6 && last_idx == 0) begin
          total++;
          if (bus.dig_o !== ((f == 0) ? 8'h83 : 8'h99)) begin
            bad++; $display("FAIL shadow_frame%0d_digit0: got %h want %h", f, bus.dig_o, (f == 0) ? 8'h83 : 8'h99);
          end
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    while (t % SD != 5) tick();
    rst = 1'b1;
    #1;
    total++;
    if (bus.sel_o !== 4'hF || bus.dig_o !== 8'hFF || bus.frame_o !== 1'b0) begin
      bad++; $display("FAIL reset_mid: got %b/%h/%b want 1111/ff/0", bus.sel_o, bus.dig_o, bus.frame_o);
    end
    #1;
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 3 * FRAME; i++) begin
      if (i == FRAME + 10) load(16'hC0DE, 4'h5, 4'h0);
      tick();
      bus.load_i = 1'b0;
      total++;
      if (bus.sel_o !== exp_sel || bus.dig_o !== exp_dig || bus.frame_o !== exp_frame) begin
        bad++;
        $display("FAIL after_reset t=%0d: got %b/%h/%b want %b/%h/%b", t, bus.sel_o, bus.dig_o, bus.frame_o, exp_sel, exp_dig, exp_frame);
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] d;
    for (int i = 0; i < 16 * FRAME; i++) begin
      bus.load_i = 1'b0;
      if ($urandom_range(0, 19) == 0) bus.bright_i = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 49) == 0) bus.lzb_en_i = ~bus.lzb_en_i;
      if ($urandom_range(0, 29) == 0) begin
        for (int k = 0; k < ND; k++)
          d[4*k +: 4] = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(1, 15)) : 4'h0;
        load(d, 4'($urandom), ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0);
      end
      tick();
      total++;
      if (bus.sel_o !== exp_sel || bus.dig_o !== exp_dig || bus.frame_o !== exp_frame) begin
        bad++;
        $display("FAIL random t=%0d: got %b/%h/%b want %b/%h/%b", t, bus.sel_o, bus.dig_o, bus.frame_o, exp_sel, exp_dig, exp_frame);
      end
    end
    bus.load_i = 1'b0;
  endtask

`ifdef SMG_BLINK_EN
  task automatic test_blink();
    bus.bright_i = 4'd15; bus.lzb_en_i = 1'b0;
    bus.blink_i = 4'b0001;
    load(16'h5678, 4'h0, 4'h0);
    tick();
    bus.load_i = 1'b0;
    bus.blink_i = 4'b0000;
    repeat (8 * FRAME) begin
      tick();
      total++;
      if (bus.sel_o !== exp_sel || bus.dig_o !== exp_dig || bus.frame_o !== exp_frame) begin
        bad++;
        $display("FAIL blink t=%0d: got %b/%h/%b want %b/%h/%b", t, bus.sel_o, bus.dig_o, bus.frame_o, exp_sel, exp_dig, exp_frame);
      end
    end
  endtask
`endif

  initial begin
    total = 0; bad = 0;
    bus.digits_i = '0; bus.dp_i = '0; bus.blank_i = '0;
    bus.lzb_en_i = 1'b0; bus.bright_i = '0; bus.load_i = 1'b0;
`ifdef SMG_BLINK_EN
    bus.blink_i = '0;
`endif
    model_reset();
    test_reset();
    test_basic();
    test_lzb();
    test_bright();
    test_shadow();
    test_reset_mid();
    test_random();
`ifdef SMG_BLINK_EN
    test_blink();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
